// File: rtl/tt_mux_sel_seq_if.sv
//------------------------------------------------------------------------------
// Module      : tt_mux_sel_seq_if
// Description : Request and ripple-counter control bundle for tt_mux_sel_seq.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tt_mux_sel_seq_if;
    logic       req_valid;
    logic [9:0] req_addr;
    logic       req_en;
    logic       req_ready;
    logic       ctrl_sel_rst_n;
    logic       ctrl_sel_inc;
    logic       ctrl_ena;
    logic [9:0] cur_addr;

    modport master (
        output req_valid, req_addr, req_en,
        input  req_ready, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, cur_addr
    );

    modport slave (
        input  req_valid, req_addr, req_en,
        output req_ready, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, cur_addr
    );
endinterface

`default_nettype wire

// File: rtl/tt_mux_sel_seq.sv
//------------------------------------------------------------------------------
// Module      : tt_mux_sel_seq
// Description : Steps a downstream ripple select counter to a requested address.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tt_mux_sel_seq #(
    parameter int HALF_PERIOD   = 2,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    tt_mux_sel_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DIS    = 3'd1,
        S_RST    = 3'd2,
        S_INC_HI = 3'd3,
        S_INC_LO = 3'd4,
        S_SETTLE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Timers count down to zero, so they are loaded with length-1.
    localparam logic [7:0] c_half_load   = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] c_rst_load    = 8'(RST_CYCLES - 1);
    localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES - 1);

    state_t     r_state, w_state_nx;
    logic [7:0] r_timer, w_timer_nx;
    logic [9:0] r_count, w_count_nx;
    logic [9:0] r_cur,   w_cur_nx;
    logic [9:0] r_addr,  w_addr_nx;
    logic       r_en,    w_en_nx;
    logic       r_ena,   w_ena_nx;
    logic       r_ready, r_sel_rst_n, r_sel_inc;

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_count_nx = r_count;
        w_cur_nx   = r_cur;
        w_addr_nx  = r_addr;
        w_en_nx    = r_en;
        w_ena_nx   = r_ena;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_ready) begin
                    w_addr_nx  = bus.req_addr;
                    w_en_nx    = bus.req_en;
                    w_state_nx = S_DIS;
                end
            end
            S_DIS: begin
                if (r_addr == r_cur) begin
                    w_state_nx = S_DONE;
                end else if (r_addr > r_cur) begin
                    // The first pulse is issued on entry, so it is consumed here.
                    w_count_nx = r_addr - r_cur - 10'd1;
                    w_cur_nx   = r_cur + 10'd1;
                    w_timer_nx = c_half_load;
                    w_state_nx = S_INC_HI;
                end else begin
                    w_timer_nx = c_rst_load;
                    w_state_nx = S_RST;
                end
            end
            S_RST: begin
                if (r_timer == 8'd0) begin
                    if (r_addr != 10'd0) begin
                        w_count_nx = r_addr - 10'd1;
                        w_cur_nx   = 10'd1;
                        w_timer_nx = c_half_load;
                        w_state_nx = S_INC_HI;
                    end else begin
                        w_count_nx = 10'd0;
                        w_cur_nx   = 10'd0;
                        w_timer_nx = c_settle_load;
                        w_state_nx = S_SETTLE;
                    end
                end else begin
                    w_timer_nx = r_timer - 8'd1;
                end
            end
            S_INC_HI: begin
                if (r_timer == 8'd0) begin
                    w_timer_nx = c_half_load;
                    w_state_nx = S_INC_LO;
                end else begin
                    w_timer_nx = r_timer - 8'd1;
                end
            end
            S_INC_LO: begin
                if (r_timer != 8'd0) begin
                    w_timer_nx = r_timer - 8'd1;
                end else if (r_count != 10'd0) begin
                    w_count_nx = r_count - 10'd1;
                    w_cur_nx   = r_cur + 10'd1;
                    w_timer_nx = c_half_load;
                    w_state_nx = S_INC_HI;
                end else begin
                    w_timer_nx = c_settle_load;
                    w_state_nx = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_timer == 8'd0) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_timer_nx = r_timer - 8'd1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Enable drops for the whole sequence and is only restored in DONE.
        if (w_state_nx == S_DIS) begin
            w_ena_nx = 1'b0;
        end else if (w_state_nx == S_DONE) begin
            w_ena_nx = r_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= 8'd0;
            r_count     <= 10'd0;
            r_cur       <= 10'd0;
            r_addr      <= 10'd0;
            r_en        <= 1'b0;
            r_ena       <= 1'b0;
            r_ready     <= 1'b0;
            r_sel_rst_n <= 1'b0;
            r_sel_inc   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_timer     <= w_timer_nx;
            r_count     <= w_count_nx;
            r_cur       <= w_cur_nx;
            r_addr      <= w_addr_nx;
            r_en        <= w_en_nx;
            r_ena       <= w_ena_nx;
            r_ready     <= (w_state_nx == S_IDLE);
            r_sel_rst_n <= (w_state_nx != S_RST);
            r_sel_inc   <= (w_state_nx == S_INC_HI);
        end
    end

    assign bus.req_ready      = r_ready;
    assign bus.ctrl_sel_rst_n = r_sel_rst_n;
    assign bus.ctrl_sel_inc   = r_sel_inc;
    assign bus.ctrl_ena       = r_ena;
    assign bus.cur_addr       = r_cur;

endmodule

`default_nettype wire

// File: tb/tb_tt_mux_sel_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_tt_mux_sel_seq
// Description : Self-checking bench for tt_mux_sel_seq against a trace model.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tt_mux_sel_seq;
    localparam int HP = 2;
    localparam int RC = 4;
    localparam int SC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tt_mux_sel_seq_if bus ();

    tt_mux_sel_seq #(
        .HALF_PERIOD   (HP),
        .RST_CYCLES    (RC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       rst_n;
        logic       inc;
        logic       ena;
        logic       ready;
        logic [9:0] cur;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp = '0;
    int   m_cur   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(input logic rn, input logic inc, input logic ena, input int cur);
        exp_t e;
        e.rst_n = rn;
        e.inc   = inc;
        e.ena   = ena;
        e.ready = 1'b0;
        e.cur   = 10'(cur);
        exp_q.push_back(e);
    endtask

    // Whole-transaction trace: one entry per cycle following the acceptance edge.
    task automatic build(input int a, input logic en);
        int c;
        exp_t d;
        c = m_cur;
        push(1'b1, 1'b0, 1'b0, c);
        if (a < c) begin
            repeat (RC) push(1'b0, 1'b0, 1'b0, c);
            c = 0;
        end
        for (int k = 0; k < a - c; k++) begin
            repeat (HP) push(1'b1, 1'b1, 1'b0, c + k + 1);
            repeat (HP) push(1'b1, 1'b0, 1'b0, c + k + 1);
        end
        if (a != m_cur) repeat (SC) push(1'b1, 1'b0, 1'b0, a);
        push(1'b1, 1'b0, en, a);
        m_cur = a;
    endtask

    always @(posedge rst) begin
        exp_q.delete();
        cur_exp = '0;
        m_cur   = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (cur_exp.ready && bus.req_valid) build(int'(bus.req_addr), bus.req_en);
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            else cur_exp = '{rst_n: 1'b1, inc: 1'b0, ena: cur_exp.ena, ready: 1'b1, cur: 10'(m_cur)};
            #1;
            chk("ready",  bus.req_ready,      cur_exp.ready);
            chk("rst_n",  bus.ctrl_sel_rst_n, cur_exp.rst_n);
            chk("inc",    bus.ctrl_sel_inc,   cur_exp.inc);
            chk("ena",    bus.ctrl_ena,       cur_exp.ena);
            chk("cur",    bus.cur_addr,       cur_exp.cur);
        end
    end

    // Drives one request and measures it in edges after the acceptance edge.
    task automatic do_req(input int a, input logic e, output int k_ready, output int k_ena,
                          output int pulses, output int rstlow);
        logic prev_inc;
        int   k;
        prev_inc = 1'b0;
        k        = 0;
        k_ready  = -1;
        k_ena    = -1;
        pulses   = 0;
        rstlow   = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 10'(a);
        bus.req_en    = e;
        @(posedge clk); #1;
        while (k < 6000) begin
            if (bus.ctrl_sel_inc && !prev_inc) pulses++;
            prev_inc = bus.ctrl_sel_inc;
            if (!bus.ctrl_sel_rst_n) rstlow++;
            if (bus.ctrl_ena && k_ena < 0) k_ena = k;
            if (bus.req_ready) begin
                k_ready = k;
                break;
            end
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_addr  = 10'($urandom);
            bus.req_en    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        bus.req_valid = 1'b0;
        if (k_ready < 0) chk("req_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kr, ke, np, nr, k;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_en    = 1'b0;

        #2;
        chk("rst_ready", bus.req_ready,      0);
        chk("rst_rst_n", bus.ctrl_sel_rst_n, 0);
        chk("rst_inc",   bus.ctrl_sel_inc,   0);
        chk("rst_ena",   bus.ctrl_ena,       0);
        chk("rst_cur",   bus.cur_addr,       0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_rst_n", bus.ctrl_sel_rst_n, 1);
        chk("rel_ready", bus.req_ready,      1);
        chk("rel_cur",   bus.cur_addr,       0);
        chk("rel_inc",   bus.ctrl_sel_inc,   0);

        do_req(3, 1'b1, kr, ke, np, nr);
        chk("r3_k_ena",  ke, 21);
        chk("r3_k_rdy",  kr, 22);
        chk("r3_pulses", np, 3);
        chk("r3_rstlow", nr, 0);
        chk("r3_cur",    bus.cur_addr, 3);

        do_req(1, 1'b1, kr, ke, np, nr);
        chk("r1_rstlow", nr, 4);
        chk("r1_pulses", np, 1);
        chk("r1_cur",    bus.cur_addr, 1);
        chk("r1_ena",    bus.ctrl_ena, 1);

        do_req(1, 1'b0, kr, ke, np, nr);
        chk("eq_rstlow", nr, 0);
        chk("eq_pulses", np, 0);
        chk("eq_k_rdy",  kr, 2);
        chk("eq_ena",    bus.ctrl_ena, 0);

        do_req(1023, 1'b1, kr, ke, np, nr);
        chk("max_pulses", np, 1022);
        chk("max_cur",    bus.cur_addr, 1023);

        do_req(0, 1'b1, kr, ke, np, nr);
        chk("zero_rstlow", nr, 4);
        chk("zero_pulses", np, 0);
        chk("zero_cur",    bus.cur_addr, 0);
        chk("zero_k_ena",  ke, 1 + RC + SC);

        do_req(0, 1'b0, kr, ke, np, nr);
        do_req(1023, 1'b1, kr, ke, np, nr);
        chk("full_pulses", np, 1023);
        chk("full_cur",    bus.cur_addr, 1023);
        do_req(2, 1'b0, kr, ke, np, nr);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_req(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), kr, ke, np, nr);
        end

        // Abort in the middle of a 5-pulse request.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 10'(m_cur + 5);
        bus.req_en    = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        k = 0;
        while (!bus.ctrl_sel_inc && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_inc_seen", bus.ctrl_sel_inc, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_inc",   bus.ctrl_sel_inc,   0);
        chk("abort_rst_n", bus.ctrl_sel_rst_n, 0);
        chk("abort_ena",   bus.ctrl_ena,       0);
        chk("abort_ready", bus.req_ready,      0);
        chk("abort_cur",   bus.cur_addr,       0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("post_cur",   bus.cur_addr,       0);
        chk("post_ready", bus.req_ready,      1);
        chk("post_rst_n", bus.ctrl_sel_rst_n, 1);

        do_req(7, 1'b1, kr, ke, np, nr);
        chk("post_pulses", np, 7);
        chk("post_cur7",   bus.cur_addr, 7);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
